// File: rtl/rr_mux8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package rr_mux8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int HOLD_W  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux8_w.sv
// Combinational 8:1 slice mux; output forced to zero whenever no grant is active.
module mux8_w
  import rr_mux8_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_REQ*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      valid,
  output logic [DATA_W-1:0]         dout
);

  // Pick the selected slice, gated by valid so an idle path reads as zero.
  always_comb begin
    dout = '0;
    if (valid) begin
      dout = din[sel*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one select datapath.
// Each grant lasts at most MAX_HOLD cycles; the releasing requester drops to
// lowest priority so a steady requester cannot starve the others.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no grant; first request from ptr wins next edge
// ST_GRANT | gnt[sel] active; hold_cnt counts burst cycles
module rr_mux8_arbiter
  import rr_mux8_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic                      valid,
  output logic [DATA_W-1:0]         dout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [SEL_W-1:0]    search_base;
  logic [SEL_W:0]      pick;
  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                release_now;

  // Returns {found, index} of the first set request at or above start, wrapping 7->0.
  // The loop runs downward so the candidate closest to start is written last and wins.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0]   result;
    result = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (r[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  // In a burst the search starts just past the current owner, which is also
  // where ptr lands on release, so the owner is considered last.
  always_comb begin
    search_base = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q;
    pick        = rr_pick(req, search_base);
    pick_found  = pick[SEL_W];
    pick_idx    = pick[SEL_W-1:0];
    release_now = (state_q == ST_GRANT) && (!req[sel_q] || (hold_q == HOLD_LAST));
  end

  // Next-state logic: start, extend, hand over or end a grant.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_d  = sel_q + 3'd1;
          hold_d = '0;
          if (pick_found) begin
            sel_d = pick_idx;
            gnt_d = NUM_REQ'(1) << pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Single register bank for FSM state, pointer, burst counter and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;

  mux8_w #(.DATA_W(DATA_W)) u_mux (
    .din   (din),
    .sel   (sel_q),
    .valid (valid),
    .dout  (dout)
  );

endmodule
